// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot image loader.
// The master side is the byte source and memory observer; the slave side is the loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot image loader: parses a 16-bit LE word count followed by LE instruction words
// from a byte stream and writes them into the instruction memory, holding the core in busy.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 65536
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  // 17-bit limit so that the default capacity admits every 16-bit count
  localparam logic [16:0] MAX_CNT = (MAX_WORDS > 32'd65536) ? 17'h1_0000 : 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [16:0] len_full;
  logic        xfer;

  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign busy         = bus.in_ready || (state == WRITE);
  assign done         = (state == DONE);
  assign err          = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // Full count as it will be once the high byte now on the bus is taken
    len_full  = {1'b0, bus.in_data, len[7:0]};
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
      LEN_LO:          if (xfer) state_nxt = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_full == 17'd0)         state_nxt = DONE;
          else if (len_full > MAX_CNT)   state_nxt = ERR;
          else                           state_nxt = DATA;
        end
      end
      DATA:            if (xfer && (byte_idx == 2'd3)) state_nxt = WRITE;
      WRITE: begin
        if (({1'b0, word_idx} + 17'd1) == {1'b0, len}) state_nxt = DONE;
        else                                           state_nxt = DATA;
      end
      default:         state_nxt = IDLE;
    endcase
  end

  // Datapath: header capture, in-place word assembly and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len           <= 16'd0;
      word_idx      <= 16'd0;
      byte_idx      <= 2'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= 32'd0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
          end
        end
        LEN_LO: if (xfer) len[7:0]  <= bus.in_data;
        LEN_HI: if (xfer) len[15:8] <= bus.in_data;
        DATA: begin
          if (xfer) begin
            bus.mem_wdata[{byte_idx, 3'b000} +: 8] <= bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.mem_we   <= 1'b1;
              bus.mem_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          byte_idx <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized image loads against a byte-counting
// reference model, plus directed header, stall, start-ignore and reset-abort scenarios.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;

  imem_loader_if ifc ();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (ifc),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: tracks how many bytes of the current image were taken
  bit          m_busy = 0, m_wr = 0, m_done = 0, m_err = 0;
  int          m_nb = 0, m_cnt = 0, m_widx = 0, m_k = 0;
  logic [31:0] m_word = 0, m_addr = BASE, m_data = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] img[16];
  logic [31:0] ref_a[$];
  logic [31:0] ref_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_wr = 0; m_done = 0; m_err = 0;
      m_nb = 0; m_cnt = 0; m_widx = 0; m_addr = BASE;
    end else if (m_wr) begin
      m_wr = 0;
      m_widx++;
      if (m_widx == m_cnt) begin m_busy = 0; m_done = 1; end
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; m_err = 0; m_nb = 0; m_widx = 0; m_cnt = 0;
      end
    end else if (ifc.in_valid) begin
      m_nb++;
      if (m_nb == 1) m_cnt = int'(ifc.in_data);
      else if (m_nb == 2) begin
        m_cnt += int'(ifc.in_data) * 256;
        if (m_cnt == 0)        begin m_busy = 0; m_done = 1; end
        else if (m_cnt > MAXW) begin m_busy = 0; m_err = 1; end
      end else begin
        m_k = (m_nb - 3) % 4;
        m_word[8*m_k +: 8] = ifc.in_data;
        if (m_k == 3) begin
          m_wr   = 1;
          m_addr = BASE + 32'(4 * m_widx);
          m_data = m_word;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("mem_we",   {31'd0, ifc.mem_we},   {31'd0, m_wr});
    chk("busy",     {31'd0, busy},         {31'd0, m_busy});
    chk("done",     {31'd0, done},         {31'd0, m_done});
    chk("err",      {31'd0, err},          {31'd0, m_err});
    chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, m_busy && !m_wr});
    chk("mem_addr", ifc.mem_addr, m_addr);
    if (m_wr) chk("mem_wdata", ifc.mem_wdata, m_data);
    if (ifc.mem_we) begin
      wa_q.push_back(ifc.mem_addr);
      wd_q.push_back(ifc.mem_wdata);
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    while (!ifc.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_bound", {31'd0, t >= 50}, 32'd0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap < 0 selects a random 0..3 idle cycles before each byte after the first
  task automatic load(input int cnt, input int nw, input int gap);
    logic [7:0] hdr_lo, hdr_hi;
    int g;
    hdr_lo = 8'(cnt);
    hdr_hi = 8'(cnt >> 8);
    send_byte(hdr_lo);
    for (int i = 0; i < 2 + 4 * nw - 1; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) @(negedge clk);
      if (i == 0) send_byte(hdr_hi);
      else        send_byte(img[(i - 1) / 4][8*((i - 1) % 4) +: 8]);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt, nw;
    int bad_cnt[3];
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'd0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
    chk("rst_mem_we",   {31'd0, ifc.mem_we},   32'd0);
    chk("rst_mem_addr", ifc.mem_addr,          BASE);
    chk("rst_mem_wdata", ifc.mem_wdata,        32'd0);
    chk("rst_flags",    {29'd0, busy, done, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word reference image
    wa_q.delete(); wd_q.delete();
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    pulse_start();
    load(2, 2, 0);
    wait_idle();
    chk("t1_nwrites", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      chk("t1_addr0", wa_q[0], 32'h0000_0000);
      chk("t1_data0", wd_q[0], 32'h0000_0013);
      chk("t1_addr1", wa_q[1], 32'h0000_0004);
      chk("t1_data1", wd_q[1], 32'h0010_0093);
    end
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_ready", {31'd0, ifc.in_ready}, 32'd0);

    // Empty image
    wa_q.delete(); wd_q.delete();
    pulse_start();
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_nwrites", wa_q.size(), 32'd0);

    // Oversized counts are rejected
    bad_cnt[0] = 5; bad_cnt[1] = 32'h0100; bad_cnt[2] = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      wa_q.delete(); wd_q.delete();
      pulse_start();
      load(bad_cnt[i], 0, 0);
      @(negedge clk);
      chk("t3_err", {31'd0, err}, 32'd1);
      chk("t3_done", {31'd0, done}, 32'd0);
      chk("t3_ready", {31'd0, ifc.in_ready}, 32'd0);
      chk("t3_nwrites", wa_q.size(), 32'd0);
    end
    wa_q.delete(); wd_q.delete();
    img[0] = 32'hDEAD_BEEF;
    pulse_start();
    chk("t3_err_clr", {31'd0, err}, 32'd0);
    load(1, 1, 0);
    wait_idle();
    chk("t3_rec_n", wa_q.size(), 32'd1);
    if (wa_q.size() == 1) begin
      chk("t3_rec_addr", wa_q[0], 32'h0);
      chk("t3_rec_data", wd_q[0], 32'hDEAD_BEEF);
    end

    // Stalled stream must produce the same writes as the unstalled one
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    wa_q.delete(); wd_q.delete();
    pulse_start();
    load(3, 3, 0);
    wait_idle();
    ref_a = wa_q; ref_d = wd_q;
    wa_q.delete(); wd_q.delete();
    pulse_start();
    load(3, 3, 3);
    wait_idle();
    chk("t4_nwrites", wa_q.size(), 32'd3);
    if (wa_q.size() == 3 && ref_a.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t4_addr", wa_q[i], 32'(4 * i));
        chk("t4_data", wd_q[i], img[i]);
        chk("t4_same", wd_q[i], ref_d[i]);
      end
    end

    // start during DATA is ignored
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h33);
    pulse_start();
    send_byte(8'h22);
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) send_byte(img[1][8*i +: 8]);
    wait_idle();
    chk("t5_nwrites", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      chk("t5_addr1", wa_q[1], 32'h4);
      chk("t5_data0", wd_q[0], 32'h1122_3344);
      chk("t5_data1", wd_q[1], 32'h5566_7788);
    end

    // Reset in the middle of the second word
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready", {31'd0, ifc.in_ready}, 32'd0);
    chk("t6_we", {31'd0, ifc.mem_we}, 32'd0);
    chk("t6_addr", ifc.mem_addr, BASE);
    chk("t6_wdata", ifc.mem_wdata, 32'd0);
    chk("t6_flags", {29'd0, busy, done, err}, 32'd0);
    chk("t6_nwrites", wa_q.size(), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle_ready", {31'd0, ifc.in_ready}, 32'd0);
    chk("t6_nwrites_after", wa_q.size(), 32'd1);

    // Randomized loads, including rejected counts
    for (int r = 0; r < 20; r++) begin
      cnt = int'($urandom_range(0, MAXW + 2));
      nw  = (cnt <= MAXW) ? cnt : 0;
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      wa_q.delete(); wd_q.delete();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse_start();
      load(cnt, nw, -1);
      wait_idle();
      @(negedge clk);
      chk("rnd_nwrites", wa_q.size(), 32'(nw));
      chk("rnd_err", {31'd0, err}, {31'd0, cnt > MAXW});
      for (int i = 0; i < wa_q.size() && i < nw; i++) begin
        chk("rnd_addr", wa_q[i], BASE + 32'(4 * i));
        chk("rnd_data", wd_q[i], img[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream and writes it into the instruction word array.
- Holds the core off (busy) while loading.
- Image format: 16-bit little-endian word count, then count×4 data bytes, each word little-endian.
- Sits between the boot byte source (UART/debug link) and the instruction memory write port.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of first written word; word aligned (bits[1:0]=0)
MAX_WORDS, 65536, capacity of instruction array in words; larger counts are rejected

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
mem_we  output  1  instruction memory write enable, one cycle per word
mem_addr  output  32  byte address of write (word aligned)
mem_wdata  output  32  assembled instruction word
busy  output  1  load in progress (LEN_LO..WRITE); core held
done  output  1  load completed successfully; sticky until next start
err  output  1  header count exceeded MAX_WORDS; sticky until next start

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0; byte and word counters cleared.
- Byte transfer occurs only on a rising edge with in_valid&&in_ready. in_ready is a pure decode of state: 1 in LEN_LO, LEN_HI, DATA; 0 otherwise. in_data ignored without transfer.
- IDLE/DONE/ERR: start → LEN_LO; clear done, err, word index, byte index. start ignored in all other states.
- LEN_LO: transfer → count[7:0], go LEN_HI.
- LEN_HI: transfer → count[15:8]. Then:
  - count==0 → DONE.
  - count>MAX_WORDS → ERR.
  - otherwise → DATA.
  - Compare uses a 17-bit count so MAX_WORDS=65536 admits every 16-bit value.
- DATA: byte k (k=0..3) → mem_wdata[8k+7:8k]. Transfer of byte 3 → WRITE.
- WRITE (one cycle):
  - mem_we=1, mem_addr=BASE_ADDR+4*idx, mem_wdata=the assembled word. All are registered outputs valid during this cycle.
  - Next: idx+1==count → DONE, else idx++, byte index=0, DATA.
- Latency: write cycle immediately follows the edge accepting byte 3. Peak throughput is 1 word per 5 cycles.
- mem_addr holds last written address outside WRITE. mem_we=0 everywhere except WRITE.
- busy=1 in LEN_LO, LEN_HI, DATA, WRITE.
- DONE: done=1 held. ERR: err=1 held. Both stay set until start or reset.
- Address arithmetic: 32-bit, wraps modulo 2^32; no saturation.
- Stream stall: any number of in_valid=0 cycles between bytes is allowed, with no timeout. Partial words are never written.
- Reset mid-load: immediate abort to IDLE. No further mem_we. Already-written words are not undone.

Test Plan:
- Image 02 00 | 13 00 00 00 | 93 00 10 00 after start → two mem_we pulses: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. Then done=1, busy=0, in_ready=0.
- start, then count bytes 00 00 → no mem_we, done=1 on cycle after second byte, err=0.
- MAX_WORDS=4, count bytes 05 00 → err=1, done=0, no mem_we, in_ready=0. A subsequent start with a valid 1-word image clears err and writes addr 0x0.
- in_valid low for 3 random cycles between every byte of a 3-word image → identical writes to the no-gap run. Each mem_we occurs exactly 1 cycle after the 4th byte's accepting edge.
- start pulsed in DATA after 2 bytes of word 0 → ignored. Load completes normally, with addr and data unaffected.
- rst_n low after 6 data bytes of a 2-word image → all outputs at reset values asynchronously. Exactly one mem_we seen before reset. After release, state is IDLE and in_ready=0 until start.
